// File: rtl/count_snapshot_fifo.sv
// Samples an up-counter into a show-ahead FIFO on a capture strobe,
// presents entries on a valid/ready port and flags counter wrap-arounds.
module count_snapshot_fifo #(
    parameter int WIDTH      = 4,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  capture,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  overflow,
    output logic                  wrap_pulse
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [WIDTH-1:0]      prev_q, prev_d;
    logic                  wrap_q, wrap_d;
    logic                  push, pop;

    assign out_valid  = (level_q != '0);
    assign full       = (level_q == FULL_LVL);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign wrap_pulse = wrap_q;

    always_comb begin
        pop        = out_valid && out_ready;
        // A full FIFO still accepts a capture when the head leaves the same cycle.
        push       = capture && (!full || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (capture & ~push);
        prev_d     = count_in;
        wrap_d     = (prev_q == '1) && (count_in == '0);
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            prev_q     <= '0;
            wrap_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            prev_q     <= prev_d;
            wrap_q     <= wrap_d;
        end
    end

    // Storage is not reset; out_data masking hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= count_in;
    end

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench for count_snapshot_fifo: capture/pop ordering, full,
// overflow, async reset, pointer wrap and counter wrap detection.
module tb_count_snapshot_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic       capture;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [3:0] level;
    logic       full;
    logic       overflow;
    logic       wrap_pulse;

    int checks = 0;
    int errors = 0;

    count_snapshot_fifo #(.WIDTH(4), .DEPTH_LOG2(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .capture    (capture),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .level      (level),
        .full       (full),
        .overflow   (overflow),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int q[$];
        int prev;
        int cnt;
        int pulses;
        logic [31:0] exp_w;

        reset = 1'b1; count_in = 4'd0; capture = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_wrap", wrap_pulse, 0);
        @(negedge clk);
        reset = 1'b0;

        // three captures, no reader
        capture = 1'b1;
        count_in = 4'd2; tick;
        count_in = 4'd3; tick;
        count_in = 4'd4; tick;
        capture = 1'b0;
        chk("t1_level", level, 3);
        chk("t1_head", out_data, 2);
        out_ready = 1'b1;
        tick; chk("t1_pop1", out_data, 3);
        tick; chk("t1_pop2", out_data, 4);
        tick;
        chk("t1_empty_v", out_valid, 0);
        chk("t1_empty_d", out_data, 0);
        out_ready = 1'b0;

        // fill to full with values 5..12
        capture = 1'b1;
        for (int i = 0; i < 8; i++) begin
            count_in = 4'(5 + i);
            tick;
        end
        chk("fill_full", full, 1);
        chk("fill_level", level, 8);
        chk("fill_head", out_data, 5);
        chk("fill_ovf", overflow, 0);

        // full with simultaneous push and pop
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fp_head", out_data, 5 + i);
            count_in = 4'(13 + i);
            tick;
            chk("fp_full", full, 1);
        end
        chk("fp_ovf", overflow, 0);
        chk("fp_level", level, 8);

        // dropped capture
        out_ready = 1'b0;
        count_in = 4'd7;
        tick;
        capture = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, 8);
        chk("ovf_head", out_data, 9);

        out_ready = 1'b1;
        tick; tick; tick;
        out_ready = 1'b0;
        chk("pre_rst_level", level, 5);
        chk("pre_rst_head", out_data, 12);
        chk("pre_rst_ovf", overflow, 1);

        // asynchronous reset, no edge between assert and check
        #2 reset = 1'b1;
        #1;
        chk("arst_level", level, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_wrap", wrap_pulse, 0);
        @(negedge clk);
        reset = 1'b0;
        capture = 1'b1;
        count_in = 4'd6;
        tick;
        capture = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 6);
        chk("post_rst_level", level, 1);

        // 20 push/pop pairs at level 1 across pointer wrap
        q.push_back(6);
        capture = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("pw_head", out_data, q[0]);
            void'(q.pop_front());
            count_in = 4'((i * 3 + 1) % 16);
            q.push_back((i * 3 + 1) % 16);
            tick;
            chk("pw_level", level, 1);
        end
        chk("pw_last", out_data, q[0]);
        capture = 1'b0;
        out_ready = 1'b0;

        // free-running counter wrap detection
        @(negedge clk);
        reset = 1'b1;
        count_in = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        prev = 0;
        cnt = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            count_in = 4'(cnt);
            tick;
            exp_w = (prev == 15 && cnt == 0) ? 32'd1 : 32'd0;
            chk("wrap_cyc", wrap_pulse, exp_w);
            if (wrap_pulse === 1'b1) pulses++;
            prev = cnt;
            cnt = (cnt + 1) % 16;
        end
        chk("wrap_count", pulses, 2);

        // jump to zero from a non-all-ones value is not a wrap
        count_in = 4'd9; tick;
        count_in = 4'd0; tick;
        chk("nowrap_jump", wrap_pulse, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
